// File: rtl/voice_allocator_p.sv
// Polyphonic voice allocator: a note table with age-based voice stealing, a
// round-robin voice dispatcher, and a saturating mixer for the returned samples.
module voice_allocator_p #(
  parameter int NBANKS     = 16,
  parameter int SAMPLE_W   = 24,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clk_en,
  input  logic                      i_cmd_valid,
  input  logic [15:0]               i_data,
  output logic [6:0]                o_midi,
  output logic [6:0]                o_velocity,
  output logic [$clog2(NBANKS)-1:0] o_slot,
  input  logic [$clog2(NBANKS)-1:0] i_slot,
  input  logic                      i_active,
  input  logic [SAMPLE_W-1:0]       i_sample,
  output logic [SAMPLE_W-1:0]       o_signal,
  output logic                      o_frame_valid,
  output logic [$clog2(NBANKS):0]   o_active_count,
  output logic                      o_full,
  output logic                      o_steal
);

  localparam int SW = $clog2(NBANKS);
  localparam int AW = SAMPLE_W + SW;
  localparam logic [SW-1:0] LAST     = SW'(NBANKS - 1);
  localparam logic [SW-1:0] IDX_ONE  = SW'(1);
  localparam logic [SW:0]   CNT_ONE  = (SW + 1)'(1);
  localparam logic [SW:0]   CNT_FULL = (SW + 1)'(NBANKS);
  localparam logic signed [AW-1:0] SAT_MAX = {{(SW + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(SW + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  logic [6:0] note_q [NBANKS];
  logic [6:0] vel_q  [NBANKS];
  logic [7:0] age_q  [NBANKS];
  logic [6:0] note_d [NBANKS];
  logic [6:0] vel_d  [NBANKS];
  logic [7:0] age_d  [NBANKS];

  logic          cmd_on;
  logic [6:0]    cmd_note;
  logic [6:0]    cmd_vel;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          free_found;
  logic [SW-1:0] free_idx;
  logic [SW-1:0] old_idx;
  logic [7:0]    old_age;
  logic [SW-1:0] tgt;
  logic          steal_d;
  logic [SW:0]   cnt_d;

  logic [SW-1:0]          v_idx;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   sample_ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   shifted;
  logic [SAMPLE_W-1:0]    sat;

  assign cmd_on   = i_data[15];
  assign cmd_note = i_data[14:8];
  assign cmd_vel  = i_data[6:0];

  // Lookup of the matching slot, the lowest free slot and the oldest slot (lowest index wins ties).
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = age_q[0];
    for (int i = 0; i < NBANKS; i++) begin
      if (!hit && cmd_note != 7'd0 && note_q[i] == cmd_note) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
      if (!free_found && note_q[i] == 7'd0) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
    for (int i = 1; i < NBANKS; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = SW'(i);
      end
    end
  end

  always_comb begin
    note_d  = note_q;
    vel_d   = vel_q;
    age_d   = age_q;
    steal_d = 1'b0;
    tgt     = '0;
    if (i_cmd_valid) begin
      if (cmd_on) begin
        if (cmd_note != 7'd0) begin
          tgt     = hit ? hit_idx : (free_found ? free_idx : old_idx);
          steal_d = !hit && !free_found;
          for (int i = 0; i < NBANKS; i++) begin
            if (note_q[i] != 7'd0 && SW'(i) != tgt)
              age_d[i] = (age_q[i] == 8'hFF) ? 8'hFF : age_q[i] + 8'd1;
          end
          note_d[tgt] = cmd_note;
          vel_d[tgt]  = cmd_vel;
          age_d[tgt]  = 8'd0;
        end
      end else if (cmd_note == 7'h7F) begin
        for (int i = 0; i < NBANKS; i++) begin
          note_d[i] = 7'd0;
          vel_d[i]  = 7'd0;
          age_d[i]  = 8'd0;
        end
      end else if (hit) begin
        note_d[hit_idx] = 7'd0;
        vel_d[hit_idx]  = 7'd0;
        age_d[hit_idx]  = 8'd0;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (note_d[i] != 7'd0)
        cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBANKS; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
      o_active_count <= '0;
      o_full         <= 1'b0;
      o_steal        <= 1'b0;
    end else begin
      note_q         <= note_d;
      vel_q          <= vel_d;
      age_q          <= age_d;
      o_active_count <= cnt_d;
      o_full         <= (cnt_d == CNT_FULL);
      o_steal        <= steal_d;
    end
  end

  // The accumulator is wide enough for a full frame of samples, so only the final result saturates.
  always_comb begin
    sample_ext = i_active ? {{SW{i_sample[SAMPLE_W-1]}}, i_sample} : '0;
    sum        = acc + sample_ext;
    shifted    = sum >>> GAIN_SHIFT;
    if (shifted > SAT_MAX)
      sat = SAT_MAX[SAMPLE_W-1:0];
    else if (shifted < SAT_MIN)
      sat = SAT_MIN[SAMPLE_W-1:0];
    else
      sat = shifted[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_idx         <= '0;
      o_midi        <= '0;
      o_velocity    <= '0;
      o_slot        <= '0;
      acc           <= '0;
      o_signal      <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      if (clk_en) begin
        o_midi     <= note_q[v_idx];
        o_velocity <= vel_q[v_idx];
        o_slot     <= v_idx;
        v_idx      <= (v_idx == LAST) ? '0 : v_idx + IDX_ONE;
        if (i_slot == LAST) begin
          o_signal      <= sat;
          o_frame_valid <= 1'b1;
          acc           <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator_p.sv
// Self-checking bench for voice_allocator_p: directed scenarios plus random traffic
// compared against a behavioural note-table and frame-mix model.
module tb_voice_allocator_p;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        i_cmd_valid;
  logic [15:0] i_data;
  logic [1:0]  i_slot;
  logic        i_active;
  logic [23:0] i_sample;

  logic [6:0]  o_midi, o_velocity;
  logic [1:0]  o_slot;
  logic [23:0] o_signal;
  logic        o_frame_valid;
  logic [2:0]  o_active_count;
  logic        o_full, o_steal;

  logic [6:0]  g2_midi, g2_velocity;
  logic [1:0]  g2_slot;
  logic [23:0] g2_signal;
  logic        g2_frame_valid;
  logic [2:0]  g2_active_count;
  logic        g2_full, g2_steal;

  voice_allocator_p #(.NBANKS(NB), .SAMPLE_W(24), .GAIN_SHIFT(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .i_cmd_valid(i_cmd_valid),
    .i_data(i_data), .o_midi(o_midi), .o_velocity(o_velocity), .o_slot(o_slot),
    .i_slot(i_slot), .i_active(i_active), .i_sample(i_sample), .o_signal(o_signal),
    .o_frame_valid(o_frame_valid), .o_active_count(o_active_count), .o_full(o_full),
    .o_steal(o_steal)
  );

  voice_allocator_p #(.NBANKS(NB), .SAMPLE_W(24), .GAIN_SHIFT(2)) u_dut_g2 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .i_cmd_valid(i_cmd_valid),
    .i_data(i_data), .o_midi(g2_midi), .o_velocity(g2_velocity), .o_slot(g2_slot),
    .i_slot(i_slot), .i_active(i_active), .i_sample(i_sample), .o_signal(g2_signal),
    .o_frame_valid(g2_frame_valid), .o_active_count(g2_active_count), .o_full(g2_full),
    .o_steal(g2_steal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the voice table as plain integer arrays plus a running frame sum.
  int     m_note [NB];
  int     m_vel  [NB];
  int     m_age  [NB];
  int     m_vidx;
  longint m_acc;
  int     e_midi, e_vel, e_slot, e_fv, e_steal;
  logic [23:0] e_sig, e_sig2;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [23:0] sat24(input longint v);
    if (v > longint'(8388607)) return 24'h7FFFFF;
    if (v < longint'(-8388608)) return 24'h800000;
    return v[23:0];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NB; i++) begin
      m_note[i] = 0;
      m_vel[i]  = 0;
      m_age[i]  = 0;
    end
    m_vidx = 0; m_acc = 0;
    e_midi = 0; e_vel = 0; e_slot = 0; e_fv = 0; e_steal = 0;
    e_sig = '0; e_sig2 = '0;
  endtask

  task automatic modelCommand(input bit on, input int note, input int vel);
    int tgt;
    if (on) begin
      if (note == 0) return;
      tgt = -1;
      for (int i = 0; i < NB; i++) if (m_note[i] == note) tgt = i;
      if (tgt < 0) for (int i = NB - 1; i >= 0; i--) if (m_note[i] == 0) tgt = i;
      if (tgt < 0) begin
        for (int i = 0; i < NB; i++) if (tgt < 0 || m_age[i] > m_age[tgt]) tgt = i;
        e_steal = 1;
      end
      for (int i = 0; i < NB; i++)
        if (i != tgt && m_note[i] != 0) m_age[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
      m_note[tgt] = note; m_vel[tgt] = vel; m_age[tgt] = 0;
    end else if (note == 127) begin
      for (int i = 0; i < NB; i++) begin
        m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
    end else if (note != 0) begin
      for (int i = 0; i < NB; i++)
        if (m_note[i] == note) begin
          m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    end
  endtask

  task automatic checkAll();
    int cnt;
    cnt = 0;
    for (int i = 0; i < NB; i++) if (m_note[i] != 0) cnt++;
    checkOutput("midi", 32'(o_midi), 32'(e_midi));
    checkOutput("velocity", 32'(o_velocity), 32'(e_vel));
    checkOutput("slot", 32'(o_slot), 32'(e_slot));
    checkOutput("active_count", 32'(o_active_count), 32'(cnt));
    checkOutput("full", 32'(o_full), 32'(cnt == NB));
    checkOutput("steal", 32'(o_steal), 32'(e_steal));
    checkOutput("frame_valid", 32'(o_frame_valid), 32'(e_fv));
    checkOutput("signal", 32'(o_signal), 32'(e_sig));
    checkOutput("g2_frame_valid", 32'(g2_frame_valid), 32'(e_fv));
    checkOutput("g2_signal", 32'(g2_signal), 32'(e_sig2));
  endtask

  task automatic checkResetState();
    checkOutput("rst_midi", 32'(o_midi), 32'd0);
    checkOutput("rst_velocity", 32'(o_velocity), 32'd0);
    checkOutput("rst_slot", 32'(o_slot), 32'd0);
    checkOutput("rst_signal", 32'(o_signal), 32'd0);
    checkOutput("rst_count", 32'(o_active_count), 32'd0);
    checkOutput("rst_flags", {29'd0, o_frame_valid, o_full, o_steal}, 32'd0);
    checkOutput("rst_g2_signal", 32'(g2_signal), 32'd0);
  endtask

  // One clock of stimulus; the model sees the table as it was before this edge's command.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic en,
                               input logic [1:0] s, input logic a, input logic [23:0] smp);
    i_cmd_valid = v; i_data = d; clk_en = en; i_slot = s; i_active = a; i_sample = smp;
    @(posedge clk);
    #1;
    e_steal = 0;
    if (en) begin
      e_midi = m_note[m_vidx]; e_vel = m_vel[m_vidx]; e_slot = m_vidx;
      m_vidx = (m_vidx + 1) % NB;
    end
    if (v) modelCommand(d[15], int'(d[14:8]), int'(d[6:0]));
    e_fv = 0;
    if (en) begin
      if (a) m_acc += longint'($signed(smp));
      if (int'(s) == NB - 1) begin
        e_sig = sat24(m_acc); e_sig2 = sat24(m_acc >>> 2); e_fv = 1; m_acc = 0;
      end
    end
    checkAll();
  endtask

  task automatic noteCmd(input bit on, input int note, input int vel);
    applyStimulus(1'b1, {on, 7'(note), 1'b0, 7'(vel)}, 1'b0, 2'd0, 1'b0, 24'd0);
  endtask

  task automatic sweepStep(input logic [1:0] s, input logic a, input logic [23:0] smp);
    applyStimulus(1'b0, 16'd0, 1'b1, s, a, smp);
  endtask

  int exp36 [NB] = '{60, 62, 64, 0};
  logic [6:0] rnd_note;
  int pick;

  initial begin
    reset_n = 1'b1; clk_en = 1'b0; i_cmd_valid = 1'b0; i_data = '0;
    i_slot = '0; i_active = 1'b0; i_sample = '0;
    #1 reset_n = 1'b0;
    #2 checkResetState();
    modelReset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Three notes fill slots 0..2, then a sweep shows them in order.
    noteCmd(1, 60, 10); noteCmd(1, 62, 20); noteCmd(1, 64, 30);
    checkOutput("req36_count", 32'(o_active_count), 32'd3);
    for (int k = 0; k < NB; k++) begin
      sweepStep(2'(k), 1'b0, 24'd0);
      checkOutput("req36_midi", 32'(o_midi), 32'(exp36[k]));
    end

    // Full table: the oldest voice (slot 0) is stolen.
    noteCmd(1, 65, 40);
    noteCmd(1, 67, 50);
    checkOutput("req37_steal", 32'(o_steal), 32'd1);
    checkOutput("req37_full", 32'(o_full), 32'd1);
    sweepStep(2'd0, 1'b0, 24'd0);
    checkOutput("req37_midi0", 32'(o_midi), 32'd67);
    for (int k = 1; k < NB; k++) sweepStep(2'(k), 1'b0, 24'd0);

    // Retrigger, absent note-off and STOP_ALL.
    noteCmd(0, 127, 0);
    noteCmd(1, 60, 10); noteCmd(1, 60, 100);
    checkOutput("req38_count", 32'(o_active_count), 32'd1);
    noteCmd(0, 61, 0);
    checkOutput("req38_count_off61", 32'(o_active_count), 32'd1);
    for (int k = 0; k < NB; k++) sweepStep(2'(k), 1'b0, 24'd0);
    noteCmd(0, 127, 0);
    checkOutput("req38_stop_all", 32'(o_active_count), 32'd0);

    // Positive full-scale on every slot saturates the mix.
    for (int k = 0; k < NB; k++) sweepStep(2'(k), 1'b1, 24'h7FFFFF);
    checkOutput("req39_sat", 32'(o_signal), 32'h7FFFFF);
    checkOutput("req39_fv", 32'(o_frame_valid), 32'd1);
    for (int k = 0; k < NB; k++) sweepStep(2'(k), 1'b1, 24'h800000);
    checkOutput("neg_sat", 32'(o_signal), 32'h800000);

    // clk_en low freezes the sweep while a note-on lands in the table.
    sweepStep(2'd0, 1'b1, 24'd5);
    sweepStep(2'd1, 1'b1, 24'd6);
    for (int k = 0; k < 5; k++)
      applyStimulus(k == 2, {1'b1, 7'd70, 1'b0, 7'd33}, 1'b0, 2'd3, 1'b1, 24'd999);
    for (int k = 2; k < NB + 2; k++) sweepStep(2'(k % NB), 1'b1, 24'd7);

    // Asynchronous reset in the middle of a frame.
    sweepStep(2'd0, 1'b1, 24'd1000);
    sweepStep(2'd1, 1'b1, 24'd2000);
    i_slot = 2'd2; i_active = 1'b1; i_sample = 24'd5000; clk_en = 1'b1;
    #2 reset_n = 1'b0;
    #1 checkResetState();
    modelReset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    sweepStep(2'd2, 1'b1, 24'd10);
    sweepStep(2'd3, 1'b1, 24'd20);
    checkOutput("req41_first_frame", 32'(o_signal), 32'd30);
    for (int k = 0; k < NB; k++) sweepStep(2'(k), 1'b1, 24'(10 * (k + 1)));
    checkOutput("req41_sum", 32'(o_signal), 32'd100);
    checkOutput("req41_g2_sum", 32'(g2_signal), 32'd25);

    // Age saturation: untouched voices pin at 255 and the lowest of them is stolen.
    noteCmd(1, 61, 1); noteCmd(1, 62, 2); noteCmd(1, 63, 3);
    for (int k = 0; k < 300; k++) noteCmd(1, 60, 9);
    noteCmd(0, 62, 0); noteCmd(1, 62, 4);
    noteCmd(1, 60, 9); noteCmd(1, 80, 11);
    for (int k = 0; k < NB; k++) sweepStep(2'(k), 1'b0, 24'd0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      pick = $urandom_range(0, 9);
      rnd_note = (pick == 0) ? 7'd0 : (pick == 9) ? 7'h7F : 7'(59 + pick);
      applyStimulus(($urandom_range(0, 2) != 0),
                    {($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, rnd_note, 1'($urandom), 7'($urandom)},
                    ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 2'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 24'h7FFFFF : 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator_p.md
VOICE_ALLOCATOR_P -- requirements
Module: voice_allocator_p

Interface
REQ-001 Parameter NBANKS, default 16: number of voice slots; legal range 2..64.
REQ-002 Parameter SAMPLE_W, default 24: width of the per-voice sample and of o_signal.
REQ-003 Parameter GAIN_SHIFT, default 2: arithmetic right shift applied to the mix sum before saturation.
REQ-004 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port clk_en  in  1  pipeline advance strobe; dispatch and mix act only when high.
REQ-007 Port i_cmd_valid  in  1  i_data carries a command this cycle.
REQ-008 Port i_data  in  16  [15]=1 note-on / 0 note-off, [14:8]=note, [7]=reserved (ignored), [6:0]=velocity.
REQ-009 Port o_midi  out  7  note of the dispatched slot; 0 = slot empty.
REQ-010 Port o_velocity  out  7  velocity of the dispatched slot.
REQ-011 Port o_slot  out  clog2(NBANKS)  index of the dispatched slot.
REQ-012 Port i_slot  in  clog2(NBANKS)  slot tag returned by the synthesis pipeline with i_sample.
REQ-013 Port i_active  in  1  i_sample belongs to a sounding voice.
REQ-014 Port i_sample  in  SAMPLE_W  signed voice sample from the pipeline.
REQ-015 Port o_signal  out  SAMPLE_W  signed, saturated mix of one full frame.
REQ-016 Port o_frame_valid  out  1  one-cycle pulse when o_signal updates.
REQ-017 Port o_active_count  out  clog2(NBANKS)+1  number of occupied slots.
REQ-018 Port o_full  out  1  high when o_active_count == NBANKS.
REQ-019 Port o_steal  out  1  one-cycle pulse when a note-on evicts a voice.

Function
REQ-020 Each slot SHALL hold note (7b), velocity (7b) and age (8b, saturating at 255); note 0 means empty.
REQ-021 Commands SHALL be accepted on every cycle with i_cmd_valid=1, independent of clk_en, and take effect on the next edge.
REQ-022 A note-on with note 0 SHALL be ignored.
REQ-023 A note-on whose note is already held SHALL retrigger that slot: velocity replaced, age cleared, no new slot, count unchanged.
REQ-024 A note-on for a new note SHALL fill the lowest-index empty slot, setting age 0.
REQ-025 A note-on when o_full=1 SHALL evict the slot with the largest age (lowest index on ties), write the new note there, and pulse o_steal.
REQ-026 Every accepted note-on SHALL increment the age of all other occupied slots (saturating).
REQ-027 A note-off SHALL clear the one slot holding that note; a note-off for an absent note SHALL be ignored.
REQ-028 A note-off with note 0x7F (STOP_ALL) SHALL clear all slots and ages in one cycle.
REQ-029 o_active_count and o_full SHALL be registered and reflect the table after each update.
REQ-030 On each clk_en cycle, o_midi/o_velocity/o_slot SHALL present the table entry at v_idx as held before any same-cycle command update; v_idx then increments, wrapping NBANKS-1 -> 0.
REQ-031 On each clk_en cycle with i_active=1, i_sample SHALL be sign-extended to SAMPLE_W+clog2(NBANKS) bits and added to the accumulator; i_active=0 adds zero.
REQ-032 On a clk_en cycle with i_slot == NBANKS-1, o_signal SHALL load saturate((acc + this sample) >>> GAIN_SHIFT) to SAMPLE_W, o_frame_valid SHALL pulse, and acc SHALL clear to 0.
REQ-033 With clk_en=0, v_idx, dispatch outputs, acc and o_signal SHALL hold; o_frame_valid SHALL be 0.

Reset
REQ-034 On reset_n=0 all slots, ages, v_idx and acc SHALL clear immediately; o_midi, o_velocity, o_slot, o_signal, o_active_count = 0; o_frame_valid, o_full, o_steal = 0.
REQ-035 Reset mid-frame SHALL discard the partial sum; the first o_frame_valid after release requires a fresh i_slot == NBANKS-1.

Verification
REQ-036 NBANKS=4: note-on 60,62,64 -> slots 0,1,2 hold 60,62,64; o_active_count=3; sweep shows o_midi 60,62,64,0 on o_slot 0..3.
REQ-037 NBANKS=4 full with 60,62,64,65 (in that order), note-on 67 -> slot 0 becomes 67, o_steal pulses once, o_full stays 1.
REQ-038 Note-on 60 vel 10 then note-on 60 vel 100 -> one slot, velocity 100, count 1; note-off 61 -> no change; note-off 0x7F -> count 0.
REQ-039 NBANKS=4, GAIN_SHIFT=0, i_sample 0x7FFFFF on all four slots with i_active=1 -> o_signal=0x7FFFFF (saturated), single o_frame_valid pulse at i_slot=3.
REQ-040 clk_en held low 5 cycles during a sweep with note-on 70 issued meanwhile -> v_idx frozen; 70 appears in the next visit of its slot.
REQ-041 reset_n asserted at i_slot=2 mid-frame -> all outputs 0 asynchronously; next frame sums only post-reset samples.
